// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 74-series gate test sequencer and its golden model.
package gate_test_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic P04 = 1'b0;
   localparam logic P86 = 1'b1;

   localparam int N04 = 64;
   localparam int N86 = 256;

   localparam logic DUT_04 = 1'b0;
   localparam logic DUT_86 = 1'b1;

endpackage

// File: rtl/gate_test_golden.sv
// Golden response of the 74hc04 / 74hc86 for a given phase and vector index.
module gate_test_golden
   import gate_test_pkg::*;
(
   input  logic       phase,
   input  logic [7:0] vec,
   output logic [5:0] expected
);

   always_comb begin
      expected = '0;
      if (phase == P04) begin
         expected = ~vec[5:0];
      end else begin
         expected = {2'b00, vec[3:0] ^ vec[7:4]};
      end
   end

endmodule

// File: rtl/gate_test_sequencer.sv
// Clocked exhaustive stimulus/check sequencer for the 74hc04 and 74hc86 models:
// counts mismatches and latches the first failure.
module gate_test_sequencer
   import gate_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 8,
   parameter int EN_04         = 1,
   parameter int EN_86         = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [5:0]       hc04_a,
   input  logic [5:0]       hc04_y,
   output logic [3:0]       hc86_a,
   output logic [3:0]       hc86_b,
   input  logic [3:0]       hc86_y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic             fail_dut,
   output logic [7:0]       fail_vec,
   output logic [5:0]       fail_got
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LAST04      = 8'(N04 - 1);
   localparam logic [7:0] LAST86      = 8'(N86 - 1);

   state_t           state_q, state_d;
   logic             phase_q, phase_d;
   logic [7:0]       vec_q, vec_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [5:0]       hc04_a_q, hc04_a_d;
   logic [3:0]       hc86_a_q, hc86_a_d;
   logic [3:0]       hc86_b_q, hc86_b_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             fail_valid_q, fail_valid_d;
   logic             fail_dut_q, fail_dut_d;
   logic [7:0]       fail_vec_q, fail_vec_d;
   logic [5:0]       fail_got_q, fail_got_d;

   logic [5:0] expected;
   logic [5:0] got;
   logic       mism;
   logic       last_vec;

   gate_test_golden u_golden (
      .phase    (phase_q),
      .vec      (vec_q),
      .expected (expected)
   );

   assign got      = (phase_q == P04) ? hc04_y : {2'b00, hc86_y};
   assign mism     = (got != expected);
   assign last_vec = (phase_q == P04) ? (vec_q == LAST04) : (vec_q == LAST86);

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      vec_d        = vec_q;
      cnt_d        = cnt_q;
      hc04_a_d     = hc04_a_q;
      hc86_a_d     = hc86_a_q;
      hc86_b_d     = hc86_b_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_dut_d   = fail_dut_q;
      fail_vec_d   = fail_vec_q;
      fail_got_d   = fail_got_q;

      // abort beats start and also suppresses a CHECK on the same edge, so the
      // error record reflects only fully completed checks
      if (abort) begin
         state_d  = S_IDLE;
         hc04_a_d = '0;
         hc86_a_d = '0;
         hc86_b_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  err_d        = '0;
                  fail_valid_d = 1'b0;
                  fail_dut_d   = 1'b0;
                  fail_vec_d   = '0;
                  fail_got_d   = '0;
                  vec_d        = '0;
                  cnt_d        = '0;
                  if (EN_04 != 0) begin
                     phase_d = P04;
                     state_d = S_DRIVE;
                  end else if (EN_86 != 0) begin
                     phase_d = P86;
                     state_d = S_DRIVE;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_DRIVE: begin
               if (phase_q == P04) begin
                  hc04_a_d = vec_q[5:0];
               end else begin
                  hc86_a_d = vec_q[3:0];
                  hc86_b_d = vec_q[7:4];
               end
               cnt_d   = SETTLE_LOAD;
               state_d = S_SETTLE;
            end
            S_SETTLE: begin
               if (cnt_q == 4'd0) state_d = S_CHECK;
               else               cnt_d   = cnt_q - 4'd1;
            end
            S_CHECK: begin
               if (mism) begin
                  if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     fail_dut_d   = (phase_q == P86) ? DUT_86 : DUT_04;
                     fail_vec_d   = vec_q;
                     fail_got_d   = got;
                  end
               end
               if (!last_vec) begin
                  vec_d   = vec_q + 8'd1;
                  state_d = S_DRIVE;
               end else if (phase_q == P04 && EN_86 != 0) begin
                  phase_d  = P86;
                  vec_d    = '0;
                  hc04_a_d = '0;
                  state_d  = S_DRIVE;
               end else begin
                  hc04_a_d = '0;
                  hc86_a_d = '0;
                  hc86_b_d = '0;
                  state_d  = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         phase_q      <= P04;
         vec_q        <= '0;
         cnt_q        <= '0;
         hc04_a_q     <= '0;
         hc86_a_q     <= '0;
         hc86_b_q     <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_dut_q   <= 1'b0;
         fail_vec_q   <= '0;
         fail_got_q   <= '0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         vec_q        <= vec_d;
         cnt_q        <= cnt_d;
         hc04_a_q     <= hc04_a_d;
         hc86_a_q     <= hc86_a_d;
         hc86_b_q     <= hc86_b_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_dut_q   <= fail_dut_d;
         fail_vec_q   <= fail_vec_d;
         fail_got_q   <= fail_got_d;
      end
   end

   assign hc04_a     = hc04_a_q;
   assign hc86_a     = hc86_a_q;
   assign hc86_b     = hc86_b_q;
   assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign pass       = done && (err_q == '0);
   assign err_count  = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_dut   = fail_dut_q;
   assign fail_vec   = fail_vec_q;
   assign fail_got   = fail_got_q;

endmodule
